// File: rtl/pipe_hazard_tracker.sv
// rtl/pipe_hazard_tracker.sv - in-order pipeline hazard tracker: forwarding selects, load-use stall, branch flush, exception freeze
module pipe_hazard_tracker #(
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 2,
  parameter int RN         = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RN-1:0]    id_rs1,
  input  logic [RN-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RN-1:0]    id_rd,
  input  logic             id_regwrite,
  input  logic             id_load,
  input  logic             id_exception,
  input  logic             ex_branch_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic [DEPTH-1:0] fwd_sel1,
  output logic [DEPTH-1:0] fwd_sel2,
  output logic             freeze,
  output logic             wb_valid,
  output logic             wb_regwrite,
  output logic [RN-1:0]    wb_rd,
  output logic [31:0]      retired_cnt,
  output logic [31:0]      stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic [RN-1:0] rd;
    logic          regwrite;
    logic          load;
    logic          exception;
    logic [RN-1:0] rs1;
    logic [RN-1:0] rs2;
    logic          use_rs1;
    logic          use_rs2;
  } slot_t;

  slot_t       ex_q, ex_d;
  slot_t       pipe_q [1:DEPTH];
  slot_t       pipe_d [1:DEPTH];
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;
  logic        lu_stall;
  logic        stall_evt;

  function automatic logic prod_match(input slot_t s, input logic [RN-1:0] rs);
    return s.valid && s.regwrite && (s.rd != '0) && (s.rd == rs);
  endfunction

  // Nearest producer wins; an unready load yields the register file (a stall covers that case).
  function automatic logic [DEPTH-1:0] fwd_for(input logic [RN-1:0] rs, input logic use_rs);
    logic [DEPTH-1:0] sel;
    sel = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (ex_q.valid && use_rs && prod_match(pipe_q[k], rs)) begin
        if (pipe_q[k].load && (k < LOAD_READY))
          sel = '0;
        else
          sel = {{(DEPTH-1){1'b0}}, 1'b1} << (k - 1);
      end
    end
    return sel;
  endfunction

  function automatic logic lu_hit(input logic [RN-1:0] rs, input logic use_rs);
    logic hit;
    hit = ex_q.load && prod_match(ex_q, rs);
    for (int k = 1; k <= DEPTH; k++) begin
      if ((k + 1 < LOAD_READY) && pipe_q[k].load && prod_match(pipe_q[k], rs))
        hit = 1'b1;
    end
    return use_rs && (rs != '0) && hit;
  endfunction

  always_comb begin
    freeze    = pipe_q[DEPTH].valid && pipe_q[DEPTH].exception;
    lu_stall  = id_valid && (lu_hit(id_rs1, id_use_rs1) || lu_hit(id_rs2, id_use_rs2));
    stall_evt = !freeze && lu_stall && !ex_branch_taken;
    stall_if  = freeze || stall_evt;
    stall_id  = freeze || stall_evt;
    flush_id  = !freeze && ex_branch_taken;
    fwd_sel1  = fwd_for(ex_q.rs1, ex_q.use_rs1);
    fwd_sel2  = fwd_for(ex_q.rs2, ex_q.use_rs2);
  end

  assign wb_valid    = pipe_q[DEPTH].valid && !pipe_q[DEPTH].exception;
  assign wb_regwrite = pipe_q[DEPTH].regwrite;
  assign wb_rd       = pipe_q[DEPTH].rd;
  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;

  always_comb begin
    ex_d      = ex_q;
    pipe_d    = pipe_q;
    retired_d = retired_q;
    stall_d   = stall_q;
    if (!freeze) begin
      for (int k = DEPTH; k >= 2; k--)
        pipe_d[k] = pipe_q[k-1];
      pipe_d[1] = ex_q;
      if (ex_branch_taken || lu_stall)
        ex_d = '0;
      else
        ex_d = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, load: id_load,
                 exception: id_exception, rs1: id_rs1, rs2: id_rs2,
                 use_rs1: id_use_rs1, use_rs2: id_use_rs2};
      if (wb_valid)
        retired_d = retired_q + 32'd1;
      if (stall_evt)
        stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q      <= '0;
      for (int k = 1; k <= DEPTH; k++)
        pipe_q[k] <= '0;
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      ex_q      <= ex_d;
      for (int k = 1; k <= DEPTH; k++)
        pipe_q[k] <= pipe_d[k];
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// tb/tb_pipe_hazard_tracker.sv - scoreboard bench for pipe_hazard_tracker (DEPTH=2, LOAD_READY=2)
module tb_pipe_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_regwrite, id_load, id_exception;
  logic       ex_branch_taken;
  logic       stall_if, stall_id, flush_id, freeze;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic       wb_valid, wb_regwrite;
  logic [4:0] wb_rd;
  logic [31:0] retired_cnt, stall_cnt;

  typedef struct {
    logic [1:0]  f1, f2;
    logic        sif, sid, fl, fz, wbv, wbrw;
    logic [4:0]  wbrd;
    logic [31:0] ret, sc;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;

  pipe_hazard_tracker #(.DEPTH(2), .LOAD_READY(2), .RN(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_load(id_load), .id_exception(id_exception),
    .ex_branch_taken(ex_branch_taken), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .freeze(freeze),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // One cycle of stimulus plus its hand-computed expected outputs.
  task automatic step(input logic r, v, input logic [4:0] rd, rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, rw, ld, ex, br,
                      input logic [1:0] f1, f2, input logic sif, sid, fl, fz, wbv, wbrw,
                      input logic [4:0] wbrd, input int ret, sc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rd = rd; id_rs1 = rs1; id_use_rs1 = u1;
    id_rs2 = rs2; id_use_rs2 = u2; id_regwrite = rw; id_load = ld;
    id_exception = ex; ex_branch_taken = br;
    e.f1 = f1; e.f2 = f2; e.sif = sif; e.sid = sid; e.fl = fl; e.fz = fz;
    e.wbv = wbv; e.wbrw = wbrw; e.wbrd = wbrd; e.ret = ret; e.sc = sc; e.cyc = cyc_n;
    exp_q.push_back(e);
    cyc_n++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fwd_sel1",    e.cyc, 32'(fwd_sel1),    32'(e.f1));
        chk("fwd_sel2",    e.cyc, 32'(fwd_sel2),    32'(e.f2));
        chk("stall_if",    e.cyc, 32'(stall_if),    32'(e.sif));
        chk("stall_id",    e.cyc, 32'(stall_id),    32'(e.sid));
        chk("flush_id",    e.cyc, 32'(flush_id),    32'(e.fl));
        chk("freeze",      e.cyc, 32'(freeze),      32'(e.fz));
        chk("wb_valid",    e.cyc, 32'(wb_valid),    32'(e.wbv));
        chk("wb_regwrite", e.cyc, 32'(wb_regwrite), 32'(e.wbrw));
        chk("wb_rd",       e.cyc, 32'(wb_rd),       32'(e.wbrd));
        chk("retired_cnt", e.cyc, retired_cnt,      e.ret);
        chk("stall_cnt",   e.cyc, stall_cnt,        e.sc);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst = 1'b0; id_valid = 1'b0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_regwrite = 1'b0; id_load = 1'b0;
    id_exception = 1'b0; ex_branch_taken = 1'b0;
    //    r v rd  rs1 u1 rs2 u2 rw ld ex br | f1     f2     sif sid fl fz wbv wbrw wbrd ret sc
    step(0,0, 0,  0, 0,  0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0); // reset
    step(1,1, 5,  1, 1,  2, 1, 1, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0); // add x5
    step(1,1, 6,  5, 1,  3, 1, 1, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0); // reads x5
    step(1,1, 7,  8, 1,  0, 0, 1, 1, 0, 0,  2'b01, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0); // lw x7
    step(1,1, 9,  1, 1,  7, 1, 1, 0, 0, 0,  2'b00, 2'b00, 1, 1, 0, 0, 1, 1,  5, 0, 0); // load-use
    step(1,1, 9,  1, 1,  7, 1, 1, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 1, 1,  6, 1, 1); // held ID
    step(1,1, 0,  1, 1,  0, 0, 1, 0, 0, 0,  2'b00, 2'b10, 0, 0, 0, 0, 1, 1,  7, 2, 1); // rd=x0 producer
    step(1,1,11,  0, 1,  0, 1, 1, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 3, 1); // reads x0
    step(1,1,12,  1, 1,  0, 0, 1, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 1, 1,  9, 3, 1); // lw x12
    step(1,1,13, 12, 1,  2, 1, 1, 0, 0, 1,  2'b00, 2'b00, 0, 0, 1, 0, 1, 1,  0, 4, 1); // branch beats stall
    step(1,1,14,  0, 0,  0, 0, 1, 0, 1, 0,  2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 11, 5, 1); // exception at N
    step(1,1,15,  1, 1,  0, 0, 1, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 12, 6, 1);
    step(1,1,16, 15, 1,  0, 0, 1, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 7, 1);
    step(1,0, 0,  0, 0,  0, 0, 0, 0, 0, 1,  2'b01, 2'b00, 1, 1, 0, 1, 0, 1, 14, 7, 1); // freeze at N+3
    step(1,1,17, 16, 1,  0, 0, 1, 1, 0, 0,  2'b01, 2'b00, 1, 1, 0, 1, 0, 1, 14, 7, 1); // still frozen
    step(0,0, 0,  0, 0,  0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0); // async reset, no edge
    step(1,0, 0,  0, 0,  0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    step(1,1,20,  0, 0,  0, 0, 1, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0); // first captured
    step(1,1,21, 20, 1,  0, 0, 1, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    step(1,0, 0,  0, 0,  0, 0, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    step(1,0, 0,  0, 0,  0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 20, 0, 0);
    step(1,0, 0,  0, 0,  0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 21, 1, 0);
    step(1,0, 0,  0, 0,  0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", cyc_n, 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
